// File: rtl/processador_parametrizado.sv
// Parametrised multicycle processor: register file, A/G registers, ALU, bus mux and
// a four-step control FSM with a valid/ready instruction port and carry/zero flags.
`timescale 1ns/1ps
module processador_parametrizado #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_REGS   = 8,
   parameter int IMM_SIGNED = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [15:0]           iin,
   input  logic                  iin_valid,
   output logic                  iin_ready,
   output logic [DATA_WIDTH-1:0] bus,
   output logic                  done,
   output logic                  carry,
   output logic                  zero,
   output logic [1:0]            state_dbg
);

   // Instruction handshake: an instruction is accepted on a rising edge where
   // iin_valid and iin_ready are both high; iin_ready is high only in T0 outside reset.

   localparam int RIDX = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;
   localparam logic [3:0] NR4 = 4'(NUM_REGS);

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;

   typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;

   state_t state, state_n;

   logic [2:0]            opcode_q, rx_q, ry_q;
   logic [9:0]            imm_q;
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [DATA_WIDTH-1:0] a_q, g_q;
   logic [DATA_WIDTH-1:0] rx_val, ry_val, imm_ext;
   logic [DATA_WIDTH-1:0] alu_res;
   logic [DATA_WIDTH:0]   sum;
   logic                  alu_c;
   logic                  is_alu, rx_ok, ry_ok, accept;

   assign state_dbg = state;
   assign accept    = iin_valid & iin_ready;
   assign is_alu    = (opcode_q != OP_MV) && (opcode_q != OP_MVI) && (opcode_q != 3'b111);

   // Indices beyond the implemented register count read as zero and never write.
   assign rx_ok  = ({1'b0, rx_q} < NR4);
   assign ry_ok  = ({1'b0, ry_q} < NR4);
   assign rx_val = rx_ok ? regs[rx_q[RIDX-1:0]] : '0;
   assign ry_val = ry_ok ? regs[ry_q[RIDX-1:0]] : '0;

   // A size cast of a signed value sign-extends, which also covers DATA_WIDTH == 10.
   assign imm_ext = (IMM_SIGNED != 0) ? DATA_WIDTH'($signed(imm_q)) : DATA_WIDTH'(imm_q);

   always_comb begin
      sum     = '0;
      alu_res = '0;
      alu_c   = 1'b0;
      case (opcode_q)
         OP_ADD: begin
            sum     = {1'b0, a_q} + {1'b0, bus};
            alu_res = sum[DATA_WIDTH-1:0];
            alu_c   = sum[DATA_WIDTH];
         end
         OP_SUB: begin
            sum     = {1'b0, a_q} + {1'b0, ~bus} + {{DATA_WIDTH{1'b0}}, 1'b1};
            alu_res = sum[DATA_WIDTH-1:0];
            alu_c   = sum[DATA_WIDTH];
         end
         OP_AND:  alu_res = a_q & bus;
         OP_OR:   alu_res = a_q | bus;
         OP_XOR:  alu_res = a_q ^ bus;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_n   = state;
      done      = 1'b0;
      iin_ready = 1'b0;
      bus       = g_q;
      case (state)
         T0: begin
            iin_ready = 1'b1;
            if (iin_valid) state_n = T1;
         end
         T1: begin
            if (is_alu) begin
               bus     = rx_val;
               state_n = T2;
            end else begin
               done    = 1'b1;
               state_n = T0;
               if (opcode_q == OP_MV)       bus = ry_val;
               else if (opcode_q == OP_MVI) bus = imm_ext;
            end
         end
         T2: begin
            bus     = ry_val;
            state_n = T3;
         end
         T3: begin
            bus     = g_q;
            done    = 1'b1;
            state_n = T0;
         end
         default: state_n = T0;
      endcase
      // Reset aborts the current instruction, so its done pulse is suppressed too.
      if (reset) begin
         iin_ready = 1'b0;
         done      = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= T0;
         opcode_q <= '0;
         rx_q     <= '0;
         ry_q     <= '0;
         imm_q    <= '0;
         a_q      <= '0;
         g_q      <= '0;
         carry    <= 1'b0;
         zero     <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            opcode_q <= iin[15:13];
            rx_q     <= iin[12:10];
            ry_q     <= iin[9:7];
            imm_q    <= iin[9:0];
         end
         case (state)
            T1: begin
               if (is_alu) a_q <= bus;
               else if ((opcode_q == OP_MV || opcode_q == OP_MVI) && rx_ok)
                  regs[rx_q[RIDX-1:0]] <= bus;
            end
            T2: begin
               g_q   <= alu_res;
               carry <= alu_c;
               zero  <= (alu_res == '0);
            end
            T3: begin
               if (rx_ok) regs[rx_q[RIDX-1:0]] <= g_q;
            end
            default: ;
         endcase
      end
   end

endmodule
